cache_mem_arbiter: RTL and testbench

- Shares one PULPino-style memory port (req/gnt/rvalid) between NUM_PORTS cache memory-side masters, e.g. instruction cache and data cache.
- Sits between the caches' mem_* outputs and the system memory/bus.
- Runs one transaction at a time: latch, issue, wait for response, return the response to the owner.
- Round-robin arbitration makes starvation impossible.

---
 rtl/cache_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares a single req/gnt/rvalid memory port between NUM_PORTS cache-side
// masters (e.g. instruction and data cache). One transaction is in flight at a
// time: the chosen request is latched in Idle, presented to memory in Issue
// until granted, and the response is routed back to the owner in Wait.
// Round-robin selection starts after the most recently granted port, so a
// continuously requesting port can never be starved.
//
// Ports:
//   clk, reset         clock (rising edge) and asynchronous active-high reset
//   port_addr_i        per-port address, port p at [32*p +: 32]
//   port_wdata_i       per-port write data, port p at [32*p +: 32]
//   port_we_i          per-port write enable
//   port_be_i          per-port byte enables, port p at [4*p +: 4]
//   port_req_i         per-port request, held by the master until its grant
//   port_gnt_o         grant pulse, one-hot to the owner
//   port_rvalid_o      response-valid pulse, one-hot to the owner
//   port_error_o       error qualifier, valid together with port_rvalid_o
//   port_rdata_o       shared read data, meaningful only with port_rvalid_o
//   mem_addr_o .. mem_req_o    request side of the memory port
//   mem_rdata_i .. mem_error_i response side of the memory port
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  // Cache-side ports
  input  logic [NUM_PORTS*32-1:0]   port_addr_i,
  input  logic [NUM_PORTS*32-1:0]   port_wdata_i,
  input  logic [NUM_PORTS-1:0]      port_we_i,
  input  logic [NUM_PORTS*4-1:0]    port_be_i,
  input  logic [NUM_PORTS-1:0]      port_req_i,
  output logic [NUM_PORTS-1:0]      port_gnt_o,
  output logic [NUM_PORTS-1:0]      port_rvalid_o,
  output logic [NUM_PORTS-1:0]      port_error_o,
  output logic [31:0]               port_rdata_o,
  // Memory-side port
  output logic [31:0]               mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic                      mem_req_o,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic                      mem_error_i
);

  localparam int unsigned PORT_IDX_W = $clog2(NUM_PORTS);
  localparam logic [PORT_IDX_W-1:0] LastPort = PORT_IDX_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  state_e                state_q, state_d;
  logic [PORT_IDX_W-1:0] owner_q, owner_d;
  logic [PORT_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;

  // ---------------------------------------------------------------------------
  // Unpack the flat per-port buses so they can be indexed by port number
  // ---------------------------------------------------------------------------
  logic [31:0] addr_arr  [NUM_PORTS];
  logic [31:0] wdata_arr [NUM_PORTS];
  logic [3:0]  be_arr    [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = port_addr_i[32*g +: 32];
    assign wdata_arr[g] = port_wdata_i[32*g +: 32];
    assign be_arr[g]    = port_be_i[4*g +: 4];
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requester found scanning rr_ptr, rr_ptr+1, ...
  // modulo NUM_PORTS. Works for non-power-of-two port counts as well.
  // ---------------------------------------------------------------------------
  logic                  pick_valid;
  logic [PORT_IDX_W-1:0] pick_idx;
  logic [PORT_IDX_W-1:0] cand_idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand_idx = PORT_IDX_W'((32'(rr_ptr_q) + i) % NUM_PORTS);
      if (!pick_valid && port_req_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and port-side strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    be_d          = be_q;
    port_gnt_o    = '0;
    port_rvalid_o = '0;
    port_error_o  = '0;
    mem_req_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Responses seen here belong to no live transaction and are dropped.
        if (pick_valid) begin
          owner_d = pick_idx;
          addr_d  = addr_arr[pick_idx];
          wdata_d = wdata_arr[pick_idx];
          we_d    = port_we_i[pick_idx];
          be_d    = be_arr[pick_idx];
          state_d = StIssue;
        end
      end

      StIssue: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          port_gnt_o[owner_q] = 1'b1;
          rr_ptr_d = (owner_q == LastPort) ? '0 : owner_q + PORT_IDX_W'(1);
          // A memory that answers in the grant cycle finishes the transaction
          // here; rvalid without gnt cannot belong to this request.
          if (mem_rvalid_i) begin
            port_rvalid_o[owner_q] = 1'b1;
            port_error_o[owner_q]  = mem_error_i;
            state_d                = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (mem_rvalid_i) begin
          port_rvalid_o[owner_q] = 1'b1;
          port_error_o[owner_q]  = mem_error_i;
          state_d                = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      be_q     <= be_d;
    end
  end

  // Request fields come straight from the latch so they stay stable while
  // the request is outstanding, independent of what the owner does meanwhile.
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_we_o     = we_q;
  assign mem_be_o     = be_q;

  // Zero-latency return path; only meaningful alongside port_rvalid_o.
  assign port_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Directed scenarios followed by a randomized run. A transaction-level model
// (one optional in-flight transaction plus a round-robin pointer) predicts the
// DUT outputs on every cycle; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  localparam int NP = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NP*32-1:0]  port_addr_i;
  logic [NP*32-1:0]  port_wdata_i;
  logic [NP-1:0]     port_we_i;
  logic [NP*4-1:0]   port_be_i;
  logic [NP-1:0]     port_req_i;
  logic [NP-1:0]     port_gnt_o;
  logic [NP-1:0]     port_rvalid_o;
  logic [NP-1:0]     port_error_o;
  logic [31:0]       port_rdata_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic              mem_req_o;
  logic [31:0]       mem_rdata_i;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic              mem_error_i;

  cache_mem_arbiter #(.NUM_PORTS(NP)) dut (
    .clk          (clk),
    .reset        (reset),
    .port_addr_i  (port_addr_i),
    .port_wdata_i (port_wdata_i),
    .port_we_i    (port_we_i),
    .port_be_i    (port_be_i),
    .port_req_i   (port_req_i),
    .port_gnt_o   (port_gnt_o),
    .port_rvalid_o(port_rvalid_o),
    .port_error_o (port_error_o),
    .port_rdata_o (port_rdata_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_req_o    (mem_req_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_error_i  (mem_error_i)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Transaction model: is a transaction held, has memory granted it yet,
  // who owns it, what it carries, and where the next search starts.
  bit          m_busy;
  bit          m_granted;
  int          m_owner;
  int          m_rr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [3:0]  m_be;
  logic [NP-1:0] last_gnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
  endtask

  task automatic model_reset();
    m_busy    = 0;
    m_granted = 0;
    m_owner   = 0;
    m_rr      = 0;
    m_addr    = '0;
    m_wdata   = '0;
    m_we      = 1'b0;
    m_be      = '0;
    last_gnt  = '0;
  endtask

  // Compare current outputs against the model, then advance it past the edge.
  task automatic model_step();
    logic [NP-1:0] eg, ev, ee;
    bit            er;
    bit            found;
    int            c;
    er = m_busy && !m_granted;
    eg = '0;
    ev = '0;
    ee = '0;
    if (er && mem_gnt_i) eg[m_owner] = 1'b1;
    if (m_busy && (m_granted || (er && mem_gnt_i)) && mem_rvalid_i) begin
      ev[m_owner] = 1'b1;
      ee[m_owner] = mem_error_i;
    end
    check("mem_req", 32'(mem_req_o), 32'(er));
    check("port_gnt", 32'(port_gnt_o), 32'(eg));
    check("port_rvalid", 32'(port_rvalid_o), 32'(ev));
    check("port_error", 32'(port_error_o), 32'(ee));
    check("port_rdata", port_rdata_o, mem_rdata_i);
    if (er) begin
      check("mem_addr", mem_addr_o, m_addr);
      check("mem_wdata", mem_wdata_o, m_wdata);
      check("mem_we", 32'(mem_we_o), 32'(m_we));
      check("mem_be", 32'(mem_be_o), 32'(m_be));
    end
    last_gnt = eg;

    if (!m_busy) begin
      found = 0;
      for (int i = 0; i < NP; i++) begin
        c = (m_rr + i) % NP;
        if (!found && port_req_i[c]) begin
          found     = 1;
          m_owner   = c;
          m_addr    = port_addr_i[32*c +: 32];
          m_wdata   = port_wdata_i[32*c +: 32];
          m_we      = port_we_i[c];
          m_be      = port_be_i[4*c +: 4];
          m_busy    = 1;
          m_granted = 0;
        end
      end
    end else if (!m_granted) begin
      if (mem_gnt_i) begin
        m_rr = (m_owner + 1) % NP;
        if (mem_rvalid_i) m_busy = 0;
        else m_granted = 1;
      end
    end else if (mem_rvalid_i) begin
      m_busy    = 0;
      m_granted = 0;
    end
  endtask

  // Inputs are set at +1 after the edge; checks run at +3, then next edge.
  task automatic step();
    #2;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_quiet();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_error_i  = 1'b0;
  endtask

  task automatic set_port(input int p, input logic req, input logic [31:0] a,
                          input logic [31:0] wd, input logic we, input logic [3:0] be);
    port_req_i[p]           = req;
    port_addr_i[32*p +: 32] = a;
    port_wdata_i[32*p +: 32] = wd;
    port_we_i[p]            = we;
    port_be_i[4*p +: 4]     = be;
  endtask

  // Async reset; 'stale' presents a memory response during/after the reset.
  task automatic do_reset(input logic stale);
    reset        = 1'b1;
    mem_rvalid_i = stale;
    mem_error_i  = stale;
    #1;
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_port_gnt", 32'(port_gnt_o), 32'd0);
    check("rst_port_rvalid", 32'(port_rvalid_o), 32'd0);
    check("rst_port_error", 32'(port_error_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_be", 32'(mem_be_o), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_random();
    for (int p = 0; p < NP; p++) begin
      if (port_req_i[p] && !last_gnt[p]) port_req_i[p] = ($urandom_range(0, 9) != 0);
      else port_req_i[p] = 1'($urandom_range(0, 1));
      port_addr_i[32*p +: 32]  = $urandom;
      port_wdata_i[32*p +: 32] = $urandom;
      port_we_i[p]             = 1'($urandom_range(0, 1));
      port_be_i[4*p +: 4]      = 4'($urandom);
    end
    mem_gnt_i    = ($urandom_range(0, 2) == 0);
    mem_rvalid_i = ($urandom_range(0, 4) < 2);
    mem_error_i  = ($urandom_range(0, 3) == 0);
    mem_rdata_i  = $urandom;
  endtask

  initial begin
    logic [NP-1:0] exp_gnt;
    logic [31:0]   exp_addr;

    port_addr_i  = '0;
    port_wdata_i = '0;
    port_we_i    = '0;
    port_be_i    = '0;
    port_req_i   = '0;
    mem_rdata_i  = '0;
    mem_quiet();
    model_reset();
    #2;
    do_reset(1'b0);

    // 1: port 0 read, gnt two cycles after req, rvalid one cycle later
    set_port(0, 1'b1, 32'h0000_1040, 32'h0, 1'b0, 4'hF);
    step();
    #1;
    check("t1_mem_req", 32'(mem_req_o), 32'd1);
    check("t1_mem_addr", mem_addr_o, 32'h0000_1040);
    check("t1_gnt_early", 32'(port_gnt_o), 32'd0);
    step();
    step();
    mem_gnt_i = 1'b1;
    #1;
    check("t1_gnt", 32'(port_gnt_o), 32'b01);
    step();
    port_req_i   = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    check("t1_rvalid", 32'(port_rvalid_o), 32'b01);
    check("t1_rdata", port_rdata_o, 32'hDEAD_BEEF);
    check("t1_gnt_once", 32'(port_gnt_o), 32'd0);
    check("t1_wait_req", 32'(mem_req_o), 32'd0);
    step();
    mem_quiet();
    #1;
    check("t1_rvalid_once", 32'(port_rvalid_o), 32'd0);
    step();

    // 2: both ports held through four transactions -> 0,1,0,1
    do_reset(1'b0);
    set_port(0, 1'b1, 32'hA000_0000, 32'h1111_1111, 1'b0, 4'hF);
    set_port(1, 1'b1, 32'hB000_0004, 32'h2222_2222, 1'b0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      mem_quiet();
      step();
      mem_gnt_i = 1'b1;
      exp_gnt   = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr  = (k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0004;
      #1;
      check("t2_gnt_order", 32'(port_gnt_o), 32'(exp_gnt));
      check("t2_addr", mem_addr_o, exp_addr);
      step();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = $urandom;
      step();
    end
    mem_quiet();
    port_req_i = '0;
    step();

    // 3: port 1 write with error response
    set_port(0, 1'b0, 32'hFFFF_0000, 32'hCAFE_F00D, 1'b0, 4'hF);
    set_port(1, 1'b1, 32'h2000_0008, 32'h1234_5678, 1'b1, 4'b0011);
    step();
    #1;
    check("t3_req", 32'(mem_req_o), 32'd1);
    check("t3_we", 32'(mem_we_o), 32'd1);
    check("t3_be", 32'(mem_be_o), 32'b0011);
    check("t3_wdata", mem_wdata_o, 32'h1234_5678);
    check("t3_addr", mem_addr_o, 32'h2000_0008);
    step();
    mem_gnt_i = 1'b1;
    #1;
    check("t3_gnt", 32'(port_gnt_o), 32'b10);
    step();
    port_req_i   = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_error_i  = 1'b1;
    #1;
    check("t3_error", 32'(port_error_o), 32'b10);
    check("t3_rvalid", 32'(port_rvalid_o), 32'b10);
    step();
    mem_quiet();
    step();

    // 4: gnt and rvalid in the same cycle
    set_port(0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, 4'hF);
    step();
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5555_AAAA;
    #1;
    check("t4_gnt", 32'(port_gnt_o), 32'b01);
    check("t4_rvalid", 32'(port_rvalid_o), 32'b01);
    step();
    mem_quiet();
    set_port(0, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 4'hF);
    set_port(1, 1'b1, 32'h0000_0200, 32'h0, 1'b0, 4'hF);
    #1;
    check("t4_idle", 32'(mem_req_o), 32'd0);
    step();
    mem_gnt_i = 1'b1;
    #1;
    check("t4_next_req", 32'(mem_req_o), 32'd1);
    check("t4_next_addr", mem_addr_o, 32'h0000_0200);
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    port_req_i   = '0;
    step();
    mem_quiet();
    step();

    // 5: reset mid-Wait with a stale response afterwards
    set_port(1, 1'b1, 32'h0000_0300, 32'h0, 1'b0, 4'hF);
    step();
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i  = 1'b0;
    port_req_i = 2'b11;
    do_reset(1'b1);
    #1;
    check("t5_stale_rvalid", 32'(port_rvalid_o), 32'd0);
    step();
    mem_quiet();
    mem_gnt_i = 1'b1;
    #1;
    check("t5_first_gnt", 32'(port_gnt_o), 32'b01);
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    port_req_i   = '0;
    step();
    mem_quiet();
    step();

    // 6: owner drops req during Issue; port 1 waits for Idle
    set_port(0, 1'b1, 32'h0000_0400, 32'h0, 1'b0, 4'hF);
    set_port(1, 1'b0, 32'h0000_0500, 32'h0, 1'b0, 4'hF);
    step();
    port_req_i = 2'b10;
    step();
    mem_gnt_i = 1'b1;
    #1;
    check("t6_gnt_owner", 32'(port_gnt_o), 32'b01);
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    #1;
    check("t6_rvalid_owner", 32'(port_rvalid_o), 32'b01);
    check("t6_held", 32'(mem_req_o), 32'd0);
    step();
    mem_quiet();
    #1;
    check("t6_idle", 32'(mem_req_o), 32'd0);
    step();
    mem_gnt_i = 1'b1;
    #1;
    check("t6_gnt_p1", 32'(port_gnt_o), 32'b10);
    check("t6_addr_p1", mem_addr_o, 32'h0000_0500);
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    port_req_i   = '0;
    step();
    mem_quiet();
    step();

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset(1'($urandom_range(0, 1)));
      drive_random();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
